// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: per-channel tick strobe and square/pulse output,
// with shadowed terminal-count updates over a valid/ready port and a global phase restart.
module clock_divider_multi #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 26,
  parameter logic [NUM_CH*CNT_W-1:0] RST_TC = {26'd49_999, 26'd49_999_999},
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_100MHz,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] mode,
  input  logic              sync_restart,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_tc,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);

  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [CNT_W-1:0]  atc_q    [NUM_CH];
  logic [CNT_W-1:0]  atc_d    [NUM_CH];
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  shadow_d [NUM_CH];
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] tog_q, tog_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] mode_q;

  // Out-of-range channel numbers stay ready so their writes are silently dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = ~pending_q[i];
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    atc_d     = atc_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    tog_d     = tog_q;
    tick_d    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sync_restart) begin
        cnt_d[i] = '0;
        tog_d[i] = 1'b0;
        if (pending_q[i]) atc_d[i] = shadow_q[i];
        pending_d[i] = 1'b0;
      end else if (en[i]) begin
        if (cnt_q[i] == atc_q[i]) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          tog_d[i]  = ~tog_q[i];
          if (pending_q[i]) begin
            atc_d[i]     = shadow_q[i];
            pending_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (pending_q[i]) begin
        // An idle channel has no wrap to wait for, so it takes the new count at once.
        cnt_d[i]     = '0;
        atc_d[i]     = shadow_q[i];
        pending_d[i] = 1'b0;
      end
      // Accept only happens with pending clear, so this never fights the clears above.
      if (cfg_valid && cfg_ready && (cfg_ch == CH_W'(i))) begin
        shadow_d[i]  = cfg_tc;
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= '0;
        atc_q[i]    <= RST_TC[i*CNT_W +: CNT_W];
        shadow_q[i] <= RST_TC[i*CNT_W +: CNT_W];
      end
      pending_q <= '0;
      tog_q     <= '0;
      tick_q    <= '0;
      mode_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      atc_q     <= atc_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      tog_q     <= tog_d;
      tick_q    <= tick_d;
      mode_q    <= mode;
    end
  end

  always_comb begin
    tick = tick_q;
    for (int i = 0; i < NUM_CH; i++) begin
      clk_out[i] = mode_q[i] ? tick_q[i] : tog_q[i];
    end
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Randomized scoreboard bench for clock_divider_multi: a countdown-to-wrap reference model
// predicts tick/clk_out per cycle; a monitor process pops and compares after each edge.
module tb_clock_divider_multi;

  localparam int NCH = 3;
  localparam int CW  = 8;

  logic            clk_100MHz = 1'b0;
  logic            rst = 1'b1;
  logic [NCH-1:0]  en = '0;
  logic [NCH-1:0]  mode = '0;
  logic            sync_restart = 1'b0;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [1:0]      cfg_ch = '0;
  logic [CW-1:0]   cfg_tc = '0;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  clk_out;

  clock_divider_multi #(
    .NUM_CH(NCH),
    .CNT_W (CW),
    .RST_TC({8'd6, 8'd4, 8'd9})
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .sync_restart(sync_restart),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_tc      (cfg_tc),
    .tick        (tick),
    .clk_out     (clk_out)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct {
    logic [NCH-1:0] tick;
    logic [NCH-1:0] clk;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Reference model: each channel counts down the enabled edges left before its next wrap.
  int   rst_tc[NCH] = '{9, 4, 6};
  int   m_tc[NCH], m_sh[NCH], m_left[NCH];
  bit   m_pend[NCH], m_tog[NCH], m_tick[NCH], m_mode[NCH];
  logic [NCH-1:0] cur_en = '0;
  logic [NCH-1:0] cur_mode = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_tc[i] = rst_tc[i];
      m_sh[i] = rst_tc[i];
      m_left[i] = rst_tc[i] + 1;
      m_pend[i] = 0;
      m_tog[i] = 0;
      m_tick[i] = 0;
      m_mode[i] = 0;
    end
  endfunction

  function automatic bit model_step(input logic [NCH-1:0] e, input logic [NCH-1:0] m,
                                    input bit s, input bit cv, input int ch, input int tcv);
    bit acc;
    acc = cv && (ch >= NCH || !m_pend[ch]);
    for (int i = 0; i < NCH; i++) begin
      m_mode[i] = m[i];
      m_tick[i] = 0;
      if (s) begin
        if (m_pend[i]) m_tc[i] = m_sh[i];
        m_pend[i] = 0;
        m_left[i] = m_tc[i] + 1;
        m_tog[i] = 0;
      end else if (e[i]) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_tick[i] = 1;
          m_tog[i] = !m_tog[i];
          if (m_pend[i]) begin
            m_tc[i] = m_sh[i];
            m_pend[i] = 0;
          end
          m_left[i] = m_tc[i] + 1;
        end
      end else if (m_pend[i]) begin
        m_tc[i] = m_sh[i];
        m_pend[i] = 0;
        m_left[i] = m_tc[i] + 1;
      end
    end
    if (acc && ch < NCH) begin
      m_sh[ch] = tcv;
      m_pend[ch] = 1;
    end
    return acc;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit s, input bit cv, input int ch, input int tcv, output bit acc);
    exp_t e;
    en = cur_en;
    mode = cur_mode;
    sync_restart = s;
    cfg_valid = cv;
    cfg_ch = 2'(ch);
    cfg_tc = CW'(tcv);
    #1;
    chk("cfg_ready", 32'(cfg_ready), (ch >= NCH) ? 32'd1 : 32'(!m_pend[ch]));
    acc = model_step(cur_en, cur_mode, s, cv, ch, tcv);
    for (int i = 0; i < NCH; i++) begin
      e.tick[i] = m_tick[i];
      e.clk[i] = m_mode[i] ? m_tick[i] : m_tog[i];
    end
    sb_q.push_back(e);
    @(negedge clk_100MHz);
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) step(0, 0, 0, 0, a);
  endtask

  task automatic cfg_write(input int ch, input int tcv);
    bit a = 0;
    for (int k = 0; k < 40 && !a; k++) step(0, 1, ch, tcv, a);
    if (!a) chk("cfg_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_applied(input int ch);
    for (int k = 0; k < 60 && m_pend[ch]; k++) idle(1);
    if (m_pend[ch]) chk("cfg_apply_timeout", 32'd0, 32'd1);
  endtask

  task automatic async_reset();
    bit a;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_tick", 32'(tick), 32'd0);
    chk("async_rst_clk_out", 32'(clk_out), 32'd0);
    chk("async_rst_ready", 32'(cfg_ready), 32'd1);
    #1 rst = 1'b0;
    model_reset();
    step(0, 0, 0, 0, a);
  endtask

  // Monitor: compares each post-edge output against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_100MHz);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("tick", 32'(tick), 32'(e.tick));
        chk("clk_out", 32'(clk_out), 32'(e.clk));
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit a;
    repeat (3) begin
      @(negedge clk_100MHz);
      chk("reset_tick", 32'(tick), 32'd0);
      chk("reset_clk_out", 32'(clk_out), 32'd0);
      chk("reset_ready", 32'(cfg_ready), 32'd1);
    end
    rst = 1'b0;
    model_reset();

    cur_en = '1;
    cur_mode = '0;
    idle(45);

    // Mid-period TC change on ch1.
    idle(2);
    cfg_write(1, 2);
    wait_applied(1);
    idle(12);

    // Pulse mode with TC=0, then toggle mode at TC=0.
    cfg_write(0, 0);
    cur_mode = 3'b001;
    idle(25);
    cur_mode = 3'b000;
    idle(10);

    // Enable gating on ch1 with TC=4, dropped at cnt=3.
    cfg_write(1, 4);
    wait_applied(1);
    for (int k = 0; k < 20 && (m_tc[1] + 1 - m_left[1]) != 3; k++) idle(1);
    cur_en = 3'b101;
    idle(7);
    cur_en = 3'b111;
    idle(8);
    cur_en = 3'b101;
    idle(2);
    cfg_write(1, 3);
    idle(2);
    cur_en = 3'b111;
    idle(12);

    // Restart with both ch0 and ch1 at TC=4 from arbitrary phase.
    cfg_write(0, 4);
    cfg_write(1, 4);
    idle(7);
    step(1, 0, 0, 0, a);
    idle(12);
    step(1, 1, 2, 5, a);
    idle(10);

    // Dropped write to a nonexistent channel.
    step(0, 1, 3, 1, a);
    idle(5);

    async_reset();
    idle(30);

    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NCH; i++) begin
        cur_en[i] = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 19) == 0) cur_mode[i] = ~cur_mode[i];
      end
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
      end else begin
        step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3),
             ($urandom_range(0, 4) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 6), a);
      end
    end

    idle(2);
    cfg_valid = 1'b0;
    sync_restart = 1'b0;
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk_100MHz);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/clock_divider_multi.md
# clock_divider_multi

Parametrised, multi-channel successor to the team's fixed 1 Hz / 1 kHz divider. Each of `NUM_CH` channels divides the system clock by a runtime-programmable terminal count. Each channel produces a one-cycle `tick` strobe and a `clk_out` that is either a 50 % square wave or the tick itself. Divisors are updated glitch-free through a valid/ready port, and all channels can be phase-aligned with a restart strobe. It feeds the stopwatch timebase, display multiplexing and debounce logic.

## Interface
- `NUM_CH`, default 2: number of channels (1–16).
- `CNT_W`, default 26: counter and terminal-count width.
- `RST_TC`, default {26'd49_999, 26'd49_999_999}: packed `NUM_CH*CNT_W` reset terminal counts, ch0 in the LSBs. The default gives ch0 = 1 Hz and ch1 = 1 kHz toggle outputs at 100 MHz.

- `clk_100MHz` in 1: system clock. Only clock.
- `rst` in 1: reset, asynchronous and active-high.
- `en` in NUM_CH: per-channel count enable.
- `mode` in NUM_CH: per-channel output mode. 0 = toggle (square), 1 = pulse (`clk_out` = `tick`).
- `sync_restart` in 1: one-cycle strobe that realigns all channels.
- `cfg_valid` in 1: config request.
- `cfg_ready` out 1: config accept. A transfer occurs when `cfg_valid` and `cfg_ready` are both high on a rising edge.
- `cfg_ch` in max(1,$clog2(NUM_CH)): target channel.
- `cfg_tc` in CNT_W: new terminal count.
- `tick` out NUM_CH: one-cycle strobe per channel period.
- `clk_out` out NUM_CH: divided output.

## Operation
- **Per-channel state:**
  - `cnt`, `active_tc`, `shadow_tc`, `pending`, `tog`, `tick` and registered `mode_q`.
  - All state is registered on `clk_100MHz`; outputs come from registers only.
- **Reset values:**
  - `cnt` = 0, `active_tc` = `RST_TC` slice, `pending` = 0.
  - `tog` = 0, `tick` = 0, `mode_q` = 0.
  - Outputs: `clk_out` = 0, `tick` = 0, `cfg_ready` = 1.
- **Enabled channel, each cycle:**
  - If `cnt == active_tc`: `cnt` <= 0, `tick` <= 1, `tog` <= ~`tog`.
  - If `pending` is set at that wrap, also `active_tc` <= `shadow_tc` and `pending` <= 0.
  - Otherwise: `cnt` <= `cnt` + 1 and `tick` <= 0.
- **Disabled channel:**
  - `cnt` and `tog` hold; `tick` <= 0.
  - A `pending` update is applied on the next edge, with `cnt` <= 0.
- **Period:** `tick` period = TC+1 cycles; toggle-mode `clk_out` period = 2·(TC+1) cycles, 50 % duty.
  - TC = 0: `tick` is continuously high and `clk_out` = clk/2.
- **Output mux:** `clk_out[i]` = `mode_q[i]` ? `tick[i]` : `tog[i]`. `mode_q` samples `mode` every cycle, so a mode change is visible one cycle later.
- **Config port:**
  - `cfg_ready` = ~`pending[cfg_ch]` (combinational on `cfg_ch`).
  - An accepted transfer writes `shadow_tc` and sets `pending`.
  - A `cfg_ch` >= `NUM_CH` is always ready; the write is accepted and dropped.
  - The new TC never truncates the current period; it takes effect at the next wrap.
- **`sync_restart`** (highest priority after reset), on all channels:
  - `cnt` <= 0, `tog` <= 0, `tick` <= 0.
  - A pending update is applied and `pending` is cleared.
  - A config transfer in the same cycle is still accepted; its `pending` wins over the clear.
- **Simultaneous wrap and config accept** on the same channel: cannot happen, because `cfg_ready` is low while `pending` is set. If `pending` = 0, the wrap uses the old TC and the new value becomes pending.

## Timing
- After `rst` falls with TC = T and `en` high, `cnt` reaches T at edge T. `tick` is high for the cycle after edge T+1, then again every T+1 cycles.
- `tick` is high for exactly one cycle, except when TC = 0.
- Config latency: new TC applies at the first wrap after acceptance. `cfg_ready` for that channel is low from the edge after acceptance until the edge after the applying wrap.
- `sync_restart` latency: the first `tick` occurs TC+1 cycles after the restart edge, on all enabled channels with equal TC in the same cycle.
- Asserting `rst` mid-period clears everything immediately (asynchronous); configured TCs revert to `RST_TC`.

## Test plan
- **Reset and defaults** (NUM_CH=2, RST_TC={4,9}, `en`=11, `mode`=00): ch0 `tick` every 10 cycles, ch1 every 5; `clk_out` periods 20 and 10; all outputs 0 during `rst`.
- **Config handshake:** write ch1 TC=2 mid-period. `cfg_ready` must drop. The current 5-cycle period completes, then `tick` comes every 3 cycles, and `cfg_ready` returns high.
- **Pulse mode and TC=0:** set ch0 `mode`=1 and TC=0. `clk_out[0]` = `tick[0]`, continuously 1 after the wrap. In toggle mode, TC=0 gives clk/2.
- **Enable gating:** drop `en[1]` at `cnt`=3, hold for 7 cycles, then re-raise. No ticks while low; the next tick comes 2 cycles after re-enable. A config written while disabled applies next edge with `cnt`=0.
- **sync_restart:** assert it with channels at arbitrary phase and both TC=4. The next ticks on both channels coincide 5 cycles later, and `clk_out` restarts from 0.
- **Async reset mid-operation:** pulse `rst` for less than one clock period between edges. Outputs go 0 immediately, and TCs revert to `RST_TC`.
